// File: rtl/ebi_bridge_if.sv
// External bus, command FIFO, sample FIFO and status signals of ebi_bridge.
// slave: bridge side; master: host/FIFO side.
interface ebi_bridge_if #(
  parameter int DATA_W    = 16,
  parameter int CMD_WORDS = 5,
  parameter int N_CH      = 1
);
  logic [DATA_W-1:0]           data_in;
  logic [DATA_W-1:0]           data_out;
  logic [18:0]                 addr;
  logic                        rd;
  logic                        wr;
  logic                        cs;
  logic [CMD_WORDS*DATA_W-1:0] cmd_fifo_data_in;
  logic                        cmd_fifo_wr_en;
  logic                        cmd_fifo_full;
  logic                        cmd_fifo_almost_full;
  logic [N_CH*DATA_W-1:0]      sample_fifo_data_out;
  logic [N_CH-1:0]             sample_fifo_rd_en;
  logic [N_CH-1:0]             sample_fifo_empty;
  logic [N_CH-1:0]             sample_fifo_full;
  logic [31:0]                 global_clock;
  logic                        irq;

  modport slave (
    input  data_in, addr, rd, wr, cs,
    input  cmd_fifo_full, cmd_fifo_almost_full,
    input  sample_fifo_data_out,
    input  sample_fifo_empty, sample_fifo_full,
    output data_out, cmd_fifo_data_in, cmd_fifo_wr_en,
    output sample_fifo_rd_en, global_clock, irq
  );

  modport master (
    output data_in, addr, rd, wr, cs,
    output cmd_fifo_full, cmd_fifo_almost_full,
    output sample_fifo_data_out,
    output sample_fifo_empty, sample_fifo_full,
    input  data_out, cmd_fifo_data_in, cmd_fifo_wr_en,
    input  sample_fifo_rd_en, global_clock, irq
  );
endinterface

// File: rtl/ebi_bridge.sv
// External bus bridge: command words -> cmd FIFO, sample FIFOs -> bus, STATUS/IRQ.
// Ports: clk, rst (async, active-high), b (ebi_bridge_if.slave).
// Optional 32-bit time counter enabled by macro EBI_BRIDGE_TIME_EN.
module ebi_bridge #(
  parameter int              DATA_W     = 16,
  parameter int              CMD_WORDS  = 5,
  parameter int              N_CH       = 1,
  parameter logic [DATA_W-1:0] EMPTY_WORD = DATA_W'(16'hDEAD)
) (
  input logic         clk,
  input logic         rst,
  ebi_bridge_if.slave b
);
  localparam logic [7:0] A_LAST = 8'(CMD_WORDS);
  localparam logic [7:0] A_S    = 8'(CMD_WORDS + 1);
  localparam logic [7:0] A_T    = 8'(CMD_WORDS + 1 + N_CH);
  localparam logic [7:0] A_RUN  = A_T + 8'd1;
  localparam logic [7:0] A_TL   = A_T + 8'd2;
  localparam logic [7:0] A_TH   = A_T + 8'd3;
  localparam logic [7:0] A_MASK = A_T + 8'd4;

  typedef enum logic [2:0] {
    IDLE, FETCH, COMMIT_WAIT, READ_WAIT, READ_NEXT
  } state_t;

  state_t            state;
  logic [7:0]        a;
  logic              wr_act, rd_act, is_ch;
  logic [1:0]        ch_a, ch_q;
  logic [1:0]        rd_s, wr_s;
  logic              rd_done, wr_done;
  logic              pulsed, overflow, stat_rd;
  logic              stat_clr, ov_set;
  logic [DATA_W-1:0] status, snapshot, mask, rd_word;
  logic [DATA_W-1:0] cap_rd, word_q;
  logic              emp_q;
  logic [DATA_W-1:0] cmd [CMD_WORDS];
  logic [DATA_W-1:0] cap [N_CH];
  logic [31:0]       cnt;

  assign a       = b.addr[7:0];
  assign wr_act  = b.cs & b.wr;
  assign rd_act  = b.cs & b.rd;
  assign is_ch   = (a >= A_S) && (a < A_T);
  assign ch_a    = 2'(a - A_S);
  // transaction ends: seen two cycles ago, gone one cycle ago
  assign rd_done = rd_s[1] & ~rd_s[0];
  assign wr_done = wr_s[1] & ~wr_s[0];
  assign stat_clr = rd_done & stat_rd;
  assign ov_set  = (state == COMMIT_WAIT) & wr_done & b.cmd_fifo_full;

  always_comb begin
    status    = '0;
    status[0] = b.cmd_fifo_full;
    status[1] = b.cmd_fifo_almost_full;
    status[2] = overflow;
    for (int i = 0; i < N_CH; i++) begin
      status[4+i] = b.sample_fifo_empty[i];
      status[8+i] = b.sample_fifo_full[i];
    end
  end

  always_comb begin
    cap_rd = '0;
    word_q = '0;
    emp_q  = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_a == 2'(i)) cap_rd = cap[i];
      if (ch_q == 2'(i)) begin
        word_q = b.sample_fifo_data_out[i*DATA_W +: DATA_W];
        emp_q  = b.sample_fifo_empty[i];
      end
    end
  end

  always_comb begin
    b.cmd_fifo_data_in = '0;
    for (int i = 0; i < CMD_WORDS; i++)
      b.cmd_fifo_data_in[i*DATA_W +: DATA_W] = cmd[i];
  end

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      (a == 8'd0):  rd_word = status;
      is_ch:        rd_word = cap_rd;
      (a == A_TL):  rd_word = DATA_W'(cnt[15:0]);
      (a == A_TH):  rd_word = DATA_W'(cnt[31:16]);
      (a == A_MASK): rd_word = mask;
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      ch_q                <= '0;
      pulsed              <= 1'b0;
      overflow            <= 1'b0;
      snapshot            <= '0;
      stat_rd             <= 1'b0;
      b.cmd_fifo_wr_en    <= 1'b0;
      b.sample_fifo_rd_en <= '0;
      for (int i = 0; i < N_CH; i++) cap[i] <= EMPTY_WORD;
    end else begin
      b.cmd_fifo_wr_en    <= 1'b0;
      b.sample_fifo_rd_en <= '0;
      stat_rd  <= (rd_act && a == 8'd0) | (stat_rd & ~rd_done);
      if (stat_clr) snapshot <= status;
      // a new overflow beats the clear from a STATUS read
      overflow <= ov_set | (overflow & ~stat_clr);
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (wr_act && a == A_LAST) begin
            state <= COMMIT_WAIT;
          end else if (rd_act && is_ch) begin
            ch_q  <= ch_a;
            state <= READ_WAIT;
          end
        end
        COMMIT_WAIT: begin
          if (wr_done) begin
            state <= FETCH;
            if (!b.cmd_fifo_full) b.cmd_fifo_wr_en <= 1'b1;
          end
        end
        READ_WAIT: begin
          if (rd_done) begin
            state  <= READ_NEXT;
            pulsed <= ~emp_q;
            for (int i = 0; i < N_CH; i++)
              if (ch_q == 2'(i) && !emp_q) b.sample_fifo_rd_en[i] <= 1'b1;
          end
        end
        READ_NEXT: begin
          state <= FETCH;
          for (int i = 0; i < N_CH; i++)
            if (ch_q == 2'(i)) cap[i] <= pulsed ? word_q : EMPTY_WORD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_s       <= '0;
      wr_s       <= '0;
      mask       <= '0;
      b.data_out <= '0;
      b.irq      <= 1'b0;
      for (int i = 0; i < CMD_WORDS; i++) cmd[i] <= '0;
    end else begin
      rd_s  <= {rd_s[0], rd_act};
      wr_s  <= {wr_s[0], wr_act};
      b.irq <= |((status ^ snapshot) & mask);
      if (wr_act && a == A_MASK) mask <= b.data_in;
      for (int i = 0; i < CMD_WORDS; i++)
        if (wr_act && a == 8'(i + 1)) cmd[i] <= b.data_in;
      if (rd_act) b.data_out <= rd_word;
    end
  end

`ifdef EBI_BRIDGE_TIME_EN
  logic run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (wr_act && a == A_T) begin
      cnt <= '0;
      run <= 1'b0;
    end else begin
      if (wr_act && a == A_RUN) run <= 1'b1;
      if (run) cnt <= cnt + 32'd1;
    end
  end
`else
  assign cnt = '0;
`endif

  assign b.global_clock = cnt;
endmodule

// File: doc/ebi_bridge.md
EBI_BRIDGE -- requirements
Module: ebi_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bus and word width (>=16).
REQ-002 SHALL have parameter CMD_WORDS, default 5, bus words per command (1..8).
REQ-003 SHALL have parameter N_CH, default 1, sample channels (1..4).
REQ-004 SHALL have parameter EMPTY_WORD, default 16'hDEAD, returned for a read of an empty channel.
REQ-005 SHALL have port clk, input, 1 bit, the only clock. Reset is asynchronous and active-high.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have ports data_in (input, DATA_W), data_out (output, DATA_W, registered), addr (input, 19), rd, wr, cs (inputs, 1 each), forming the external bus.
REQ-008 SHALL have ports cmd_fifo_data_in (output, CMD_WORDS*DATA_W, word k at bits [k*DATA_W +: DATA_W]), cmd_fifo_wr_en (output, 1), cmd_fifo_full and cmd_fifo_almost_full (inputs, 1 each).
REQ-009 SHALL have ports sample_fifo_data_out (input, N_CH*DATA_W), sample_fifo_rd_en, sample_fifo_empty and sample_fifo_full (N_CH each; rd_en is an output, the others are inputs).
REQ-010 SHALL have ports global_clock (output, 32) and irq (output, 1, registered).

Function
REQ-011 SHALL decode addr[7:0] as follows:
- 0: STATUS.
- 1..CMD_WORDS: command words.
- S=CMD_WORDS+1 .. S+N_CH-1: sample channels.
- T=S+N_CH: RESET_TIME; T+1: RUN_TIME; T+2: TIME_L; T+3: TIME_H; T+4: IRQ_MASK (read/write).
REQ-012 SHALL detect bus transaction end by two-flop sampling of (rd&cs) and (wr&cs); done = delayed-by-2 high and delayed-by-1 low.
REQ-013 SHALL implement the FSM with states IDLE, FETCH, COMMIT_WAIT, READ_WAIT, READ_NEXT:
- IDLE -> FETCH unconditionally.
- FETCH: a cs&wr to the last command word -> COMMIT_WAIT; a cs&rd to a sample channel -> READ_WAIT (channel index latched).
- COMMIT_WAIT -> FETCH on write-done.
- READ_WAIT -> READ_NEXT on read-done.
- READ_NEXT -> FETCH.
REQ-014 SHALL latch data_in into a command word register on every clk while cs&wr addresses that word; registers hold until rewritten.
REQ-015 On write-done in COMMIT_WAIT, SHALL pulse cmd_fifo_wr_en for exactly 1 cycle if cmd_fifo_full=0; otherwise SHALL pulse nothing and set sticky STATUS.overflow.
REQ-016 On read-done in READ_WAIT, SHALL pulse sample_fifo_rd_en[ch] for 1 cycle if sample_fifo_empty[ch]=0; in READ_NEXT SHALL load captured[ch] from the FIFO word, or EMPTY_WORD if no pulse was issued.
REQ-017 While cs&rd, SHALL register data_out by address:
- STATUS: status.
- Channel: captured[ch].
- TIME_L/TIME_H: counter [15:0]/[31:16].
- IRQ_MASK: mask.
- Undecoded address: 0.
REQ-018 SHALL form STATUS as: bit0 cmd_full, bit1 cmd_almost_full, bit2 overflow, bits 4+i sample_empty[i], bits 8+i sample_full[i]; all other bits 0.
REQ-019 A STATUS read SHALL snapshot STATUS and clear overflow; if overflow sets in the same cycle, the set wins.
REQ-020 SHALL drive irq registered, high while ((STATUS ^ snapshot) & IRQ_MASK) != 0.
REQ-021 Time counter, 32-bit:
- Write to RESET_TIME clears it and stops it.
- Write to RUN_TIME starts it.
- Increments by 1 per clk while running; wraps 0xFFFFFFFF -> 0 and keeps running.
- global_clock = counter.
REQ-022 SHALL ignore a write to any address other than command words, RESET_TIME, RUN_TIME and IRQ_MASK.

Reset
REQ-023 rst SHALL asynchronously force:
- FSM to IDLE.
- data_out, command words, IRQ_MASK, snapshot, overflow, counter, run flag, irq and all strobes to 0.
- captured[] to EMPTY_WORD.
REQ-024 An in-flight commit or read at reset SHALL be abandoned with no FIFO strobe.

Configuration
REQ-025 With macro EBI_BRIDGE_TIME_EN defined, the time counter SHALL be as in REQ-021.
REQ-026 Without EBI_BRIDGE_TIME_EN, global_clock SHALL be 0, TIME_L/TIME_H SHALL read 0, and RESET_TIME/RUN_TIME writes SHALL be ignored.

Verification
REQ-027 With CMD_WORDS=5: write 0x1111..0x5555 to addr 1..5 -> after wr release, one cmd_fifo_wr_en pulse with cmd_fifo_data_in = 0x5555_4444_3333_2222_1111.
REQ-028 With cmd_fifo_full=1: commit -> no wr_en pulse and STATUS bit2=1; next STATUS read returns bit2=1, and the following read returns bit2=0.
REQ-029 With N_CH=2 and channel 1 FIFO holding 0xBEEF: first read of addr 7 returns 0xDEAD, one rd_en[1] pulse follows, and the second read returns 0xBEEF; channel 0 is untouched.
REQ-030 Write IRQ_MASK=0x0001, then toggle cmd_fifo_full 0->1 -> irq=1 within 2 cycles; a STATUS read drops irq; toggling sample_empty (masked) leaves irq=0.
REQ-031 RUN_TIME, wait 100 clk, read TIME_L -> value 100±3; counter preloaded to 0xFFFFFFFF wraps to 0; asserting rst mid-READ_WAIT produces no rd_en pulse.
